// File: rtl/pry2oht_pkg.sv
// Shared helpers for the round-robin arbiter: mask generation and one-hot to index encoding.
// Vectors are handled at MAX_W bits and resized at the call site, so any WIDTH up to MAX_W works.
package pry2oht_pkg;

  localparam int MAX_W  = 1024;
  localparam int MAX_IW = $clog2(MAX_W);

  typedef logic [MAX_W-1:0]  vec_t;
  typedef logic [MAX_IW-1:0] idx_t;

  // Bits strictly above the set bit of oht; zero when oht is zero or at the top.
  function automatic vec_t above_mask(input vec_t oht);
    return ~((oht << 1) - vec_t'(1)) & ~oht;
  endfunction

  function automatic idx_t oht2idx(input vec_t oht);
    idx_t idx;
    idx = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (oht[i]) idx = idx | idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pry2oht_tree.sv
// Priority resolver: returns the rightmost set bit of req as a one-hot vector.
// IMPLEMENTATION 0 is a two-level tree of SPLIT groups; any other value uses the x & -x form.
module pry2oht_tree #(
  parameter int WIDTH          = 32,
  parameter int SPLIT          = 2,
  parameter int IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] oht,
  output logic             vld
);

  localparam int GW = (WIDTH + SPLIT - 1) / SPLIT;
  localparam int NG = (WIDTH + GW - 1) / GW;

  if (IMPLEMENTATION == 0) begin : g_tree
    logic [NG-1:0] grp_any;
    logic [NG-1:0] grp_blk;

    for (genvar g = 0; g < NG; g++) begin : g_grp
      localparam int LO = g * GW;
      localparam int HI = ((g + 1) * GW > WIDTH) ? WIDTH - 1 : (g + 1) * GW - 1;
      assign grp_any[g] = |req[HI:LO];
      if (g == 0) begin : g_first
        assign grp_blk[g] = 1'b0;
      end else begin : g_rest
        assign grp_blk[g] = |grp_any[g-1:0];
      end
    end

    // A bit wins if no lower group is active and no lower bit in its own group is set.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam int G  = i / GW;
      localparam int LO = G * GW;
      if (i == LO) begin : g_lead
        assign oht[i] = req[i] & ~grp_blk[G];
      end else begin : g_tail
        assign oht[i] = req[i] & ~grp_blk[G] & ~(|req[i-1:LO]);
      end
    end

    assign vld = |grp_any;
  end else begin : g_flat
    assign oht = req & (~req + WIDTH'(1));
    assign vld = |req;
  end

endmodule

// File: rtl/pry2oht_rr_arbiter.sv
// Registered round-robin arbiter with a one-hot grant held under a valid/ready handshake.
// Optional binary grant index output enabled by defining PRY2OHT_RR_ARBITER_IDX_EN.
module pry2oht_rr_arbiter
  import pry2oht_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int SPLIT          = 2,
  parameter int IMPLEMENTATION = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         req,
  output logic [WIDTH-1:0]         gnt,
  output logic                     gnt_vld,
  input  logic                     gnt_rdy
`ifdef PRY2OHT_RR_ARBITER_IDX_EN
  ,
  output logic [$clog2(WIDTH)-1:0] gnt_idx
`endif
);

  // gnt_vld | state
  //    0    | IDLE: no grant pending, load on every cycle
  //    1    | HOLD: grant presented, frozen until gnt_rdy

  logic [WIDTH-1:0] msk;
  logic [WIDTH-1:0] msk_upd;
  logic [WIDTH-1:0] msk_eff;
  logic [WIDTH-1:0] req_msk;
  logic [WIDTH-1:0] oht_msk;
  logic [WIDTH-1:0] oht_raw;
  logic [WIDTH-1:0] arb;
  logic             any_msk;
  logic             any_raw;
  logic             load;
  logic             xfer;

  assign load    = !gnt_vld || gnt_rdy;
  assign xfer    = gnt_vld && gnt_rdy;
  assign msk_upd = WIDTH'(above_mask(vec_t'(gnt)));
  // The post-transfer mask is used immediately so back-to-back grants rotate without a bubble.
  assign msk_eff = xfer ? msk_upd : msk;
  assign req_msk = req & msk_eff;
  assign arb     = any_msk ? oht_msk : oht_raw;

  pry2oht_tree #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_tree_msk (
    .req (req_msk),
    .oht (oht_msk),
    .vld (any_msk)
  );

  pry2oht_tree #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_tree_raw (
    .req (req),
    .oht (oht_raw),
    .vld (any_raw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= '0;
      gnt_vld <= 1'b0;
      msk     <= '1;
    end else begin
      if (load) begin
        gnt     <= arb;
        gnt_vld <= any_raw;
      end
      if (xfer) msk <= msk_upd;
    end
  end

`ifdef PRY2OHT_RR_ARBITER_IDX_EN
  localparam int IW = $clog2(WIDTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_idx <= '0;
    end else if (load) begin
      gnt_idx <= IW'(oht2idx(vec_t'(arb)));
    end
  end
`endif

endmodule

// File: tb/tb_pry2oht_rr_arbiter.sv
// Scoreboard bench for pry2oht_rr_arbiter at WIDTH 4, 5 and 32 against a circular-scan reference.
// Checks gnt_idx as well when PRY2OHT_RR_ARBITER_IDX_EN is defined.
module tb_pry2oht_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic [3:0]  req4 = '0;
  logic [4:0]  req5 = '0;
  logic [31:0] req32 = '0;
  logic [3:0]  gnt4;
  logic [4:0]  gnt5;
  logic [31:0] gnt32;
  logic        v4, v5, v32;
`ifdef PRY2OHT_RR_ARBITER_IDX_EN
  logic [1:0]  ix4;
  logic [2:0]  ix5;
  logic [4:0]  ix32;
`endif

  pry2oht_rr_arbiter #(.WIDTH(4), .SPLIT(2), .IMPLEMENTATION(0)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .gnt(gnt4), .gnt_vld(v4), .gnt_rdy(rdy)
`ifdef PRY2OHT_RR_ARBITER_IDX_EN
    , .gnt_idx(ix4)
`endif
  );

  pry2oht_rr_arbiter #(.WIDTH(5), .SPLIT(4), .IMPLEMENTATION(0)) dut5 (
    .clk(clk), .rst(rst), .req(req5), .gnt(gnt5), .gnt_vld(v5), .gnt_rdy(rdy)
`ifdef PRY2OHT_RR_ARBITER_IDX_EN
    , .gnt_idx(ix5)
`endif
  );

  pry2oht_rr_arbiter #(.WIDTH(32), .SPLIT(4), .IMPLEMENTATION(0)) dut32 (
    .clk(clk), .rst(rst), .req(req32), .gnt(gnt32), .gnt_vld(v32), .gnt_rdy(rdy)
`ifdef PRY2OHT_RR_ARBITER_IDX_EN
    , .gnt_idx(ix32)
`endif
  );

  typedef struct packed {
    int               due;
    logic [2:0][31:0] g;
    logic [2:0]       v;
    logic [2:0][4:0]  ix;
  } exp_t;

  typedef struct packed {
    int         due;
    logic [3:0] g;
    logic       v;
  } dexp_t;

  exp_t  sq[$];
  dexp_t dq[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int          wd[3] = '{4, 5, 32};
  logic [31:0] m_g[3];
  logic        m_v[3];
  int          m_last[3];
  bit          fair_on = 1'b0;

  function automatic int idx_of(input logic [31:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Reference: after a transfer the search starts just past the last granted
  // requester and wraps around; -1 means "start from requester 0".
  task automatic model_step(input int k, input logic [31:0] r, input logic rs, input logic rd);
    if (rs) begin
      m_g[k]    = '0;
      m_v[k]    = 1'b0;
      m_last[k] = -1;
    end else if (!m_v[k] || rd) begin
      if (m_v[k]) m_last[k] = idx_of(m_g[k]);
      m_g[k] = '0;
      m_v[k] = 1'b0;
      for (int j = 1; j <= wd[k]; j++) begin
        int c;
        c = (m_last[k] + j) % wd[k];
        if (!m_v[k] && r[c]) begin
          m_g[k] = 32'd1 << c;
          m_v[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic drive(input logic rs, input logic rd, input logic [3:0] q4, input logic [4:0] q5,
                       input logic [31:0] q32, input bit chk, input logic [3:0] eg, input logic ev);
    exp_t  e;
    dexp_t d;
    @(posedge clk);
    #1;
    rst   = rs;
    rdy   = rd;
    req4  = q4;
    req5  = q5;
    req32 = q32;
    model_step(0, {28'b0, q4}, rs, rd);
    model_step(1, {27'b0, q5}, rs, rd);
    model_step(2, q32, rs, rd);
    e.due = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      e.g[k]  = m_g[k];
      e.v[k]  = m_v[k];
      e.ix[k] = 5'(idx_of(m_g[k]));
    end
    sq.push_back(e);
    if (chk) begin
      d.due = cyc + 1;
      d.g   = eg;
      d.v   = ev;
      dq.push_back(d);
    end
  endtask

  task automatic dir(input logic rs, input logic rd, input logic [3:0] q4,
                     input logic [3:0] eg, input logic ev);
    drive(rs, rd, q4, 5'($urandom), $urandom, 1'b1, eg, ev);
  endtask

  logic [31:0] dg[3];
  logic        dv[3];
  logic [4:0]  dix[3];
  int          xn[3];
  int          flast[3][32];
  bit          fair_prev = 1'b0;

  always @(negedge clk) begin
    exp_t  e;
    dexp_t d;
    int    gi;
    dg[0] = {28'b0, gnt4};
    dg[1] = {27'b0, gnt5};
    dg[2] = gnt32;
    dv[0] = v4;
    dv[1] = v5;
    dv[2] = v32;
`ifdef PRY2OHT_RR_ARBITER_IDX_EN
    dix[0] = {3'b0, ix4};
    dix[1] = {2'b0, ix5};
    dix[2] = ix32;
`else
    for (int k = 0; k < 3; k++) dix[k] = '0;
`endif
    if (sq.size() > 0 && sq[0].due <= cyc) begin
      e = sq.pop_front();
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (dg[k] !== e.g[k]) begin
          n_bad++;
          $display("FAIL gnt w=%0d cyc=%0d got=%h exp=%h", wd[k], cyc, dg[k], e.g[k]);
        end
        n_cmp++;
        if (dv[k] !== e.v[k]) begin
          n_bad++;
          $display("FAIL gnt_vld w=%0d cyc=%0d got=%b exp=%b", wd[k], cyc, dv[k], e.v[k]);
        end
`ifdef PRY2OHT_RR_ARBITER_IDX_EN
        n_cmp++;
        if (dix[k] !== e.ix[k]) begin
          n_bad++;
          $display("FAIL gnt_idx w=%0d cyc=%0d got=%0d exp=%0d", wd[k], cyc, dix[k], e.ix[k]);
        end
`endif
      end
    end
    if (dq.size() > 0 && dq[0].due <= cyc) begin
      d = dq.pop_front();
      n_cmp++;
      if (gnt4 !== d.g || v4 !== d.v) begin
        n_bad++;
        $display("FAIL directed cyc=%0d got gnt=%b vld=%b exp gnt=%b vld=%b", cyc, gnt4, v4, d.g, d.v);
      end
    end
    if (fair_on && !fair_prev) begin
      for (int k = 0; k < 3; k++) begin
        xn[k] = 0;
        for (int i = 0; i < 32; i++) flast[k][i] = 0;
      end
    end
    fair_prev = fair_on;
    if (fair_on && rdy && !rst) begin
      for (int k = 0; k < 3; k++) begin
        if (dv[k]) begin
          gi = idx_of(dg[k]);
          n_cmp++;
          if (xn[k] - flast[k][gi] > wd[k]) begin
            n_bad++;
            $display("FAIL fairness w=%0d bit=%0d gap=%0d limit=%0d", wd[k], gi, xn[k] - flast[k][gi], wd[k]);
          end
          flast[k][gi] = xn[k];
          xn[k]++;
        end
      end
    end
  end

  initial begin
    // Reset with all requesting, then rotation.
    dir(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0);
    dir(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0);
    dir(1'b0, 1'b1, 4'b1111, 4'b0001, 1'b1);
    dir(1'b0, 1'b1, 4'b1111, 4'b0010, 1'b1);
    dir(1'b0, 1'b1, 4'b1111, 4'b0100, 1'b1);
    dir(1'b0, 1'b1, 4'b1111, 4'b1000, 1'b1);
    dir(1'b0, 1'b1, 4'b1111, 4'b0001, 1'b1);
    // Hold: requests are ignored while the grant is not accepted.
    dir(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0);
    dir(1'b0, 1'b0, 4'b0110, 4'b0010, 1'b1);
    for (int i = 0; i < 4; i++) dir(1'b0, 1'b0, 4'($urandom), 4'b0010, 1'b1);
    dir(1'b0, 1'b1, 4'b0110, 4'b0100, 1'b1);
    // Wrap from the top requester.
    dir(1'b0, 1'b1, 4'b1000, 4'b1000, 1'b1);
    dir(1'b0, 1'b1, 4'b1001, 4'b0001, 1'b1);
    // Empty then re-request.
    dir(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    dir(1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1);
    dir(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    // Single requester is re-granted every cycle.
    for (int i = 0; i < 3; i++) dir(1'b0, 1'b1, 4'b0010, 4'b0010, 1'b1);

    for (int i = 0; i < 800; i++) begin
      logic [31:0] r32;
      r32 = ($urandom_range(0, 1) == 0) ? ($urandom & $urandom) : $urandom;
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 4'($urandom), 5'($urandom),
            r32, 1'b0, 4'b0000, 1'b0);
    end

    fair_on = 1'b1;
    for (int i = 0; i < 400; i++) begin
      drive(1'b0, ($urandom_range(0, 3) != 0), 4'hF, 5'h1F, 32'hFFFF_FFFF, 1'b0, 4'b0000, 1'b0);
    end
    fair_on = 1'b0;

    drive(1'b0, 1'b1, 4'h0, 5'h00, 32'h0, 1'b0, 4'b0000, 1'b0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sq.size() != 0 || dq.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d/%0d pending exp=0/0", sq.size(), dq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
